// File: rtl/clk_step_pkg.sv
// rtl/clk_step_pkg.sv - shared encodings for the processor step controller
package clk_step_pkg;

    typedef enum logic [1:0] {
        MODE_STEP = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_HALT = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        DB_IDLE  = 2'b00,
        DB_PWAIT = 2'b01,
        DB_HELD  = 2'b10,
        DB_RWAIT = 2'b11
    } db_state_e;

endpackage

// File: rtl/clk_step_ctrl_if.sv
// rtl/clk_step_ctrl_if.sv - board-side signals of the processor step controller
interface clk_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             slow_clk_i;
    logic             run_sw_i;
    logic             step_btn_ni;
    logic             halt_i;
    logic             cpu_en_o;
    logic [1:0]       mode_o;
    logic [CNT_W-1:0] step_cnt_o;

    modport master (
        output slow_clk_i, run_sw_i, step_btn_ni, halt_i,
        input  cpu_en_o, mode_o, step_cnt_o
    );

    modport slave (
        input  slow_clk_i, run_sw_i, step_btn_ni, halt_i,
        output cpu_en_o, mode_o, step_cnt_o
    );
endinterface

// File: rtl/clk_step_ctrl_debounce.sv
// rtl/clk_step_ctrl_debounce.sv - active-low key synchronizer and debouncer, one press pulse per press
module btn_debounce
    import clk_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    // Synchronizer resets to "released" so reset never looks like a press
    logic [1:0] sync_q;
    logic       pressed;

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_ni};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = ~sync_q[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (pressed) begin
                    state_d = DB_PWAIT;
                    cnt_d   = '0;
                end
            end
            DB_PWAIT: begin
                if (!pressed) begin
                    state_d = DB_IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DB_HELD;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DB_HELD: begin
                if (!pressed) begin
                    state_d = DB_RWAIT;
                    cnt_d   = '0;
                end
            end
            DB_RWAIT: begin
                // A bounce during release returns to HELD without a new pulse
                if (pressed) begin
                    state_d = DB_HELD;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = DB_IDLE;
        endcase
    end
endmodule

// File: rtl/clk_step_ctrl.sv
// rtl/clk_step_ctrl.sv - RUN/STEP/HALT clock-enable generator and step counter for the processor
module clk_step_ctrl
    import clk_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    clk_step_ctrl_if.slave   bus
);
    // Slow clock is only sampled as data; a third flop gives the rising-edge tick
    logic [2:0]       slow_q;
    logic [1:0]       run_q;
    logic             tick;
    logic             run_sw;
    logic             press;

    mode_e            mode_q, mode_d;
    logic             cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0] step_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slow_q <= 3'b111;
            run_q  <= 2'b00;
        end else begin
            slow_q <= {slow_q[1:0], bus.slow_clk_i};
            run_q  <= {run_q[0], bus.run_sw_i};
        end
    end

    assign tick   = slow_q[1] & ~slow_q[2];
    assign run_sw = run_q[1];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_ni (bus.step_btn_ni),
        .press_o(press)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= MODE_STEP;
            cpu_en_q   <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            cpu_en_q   <= cpu_en_d;
            step_cnt_q <= step_cnt_q + {{(CNT_W-1){1'b0}}, cpu_en_q};
        end
    end

    // Enable source follows the registered mode, so a mode change never mixes sources
    always_comb begin
        mode_d   = mode_q;
        cpu_en_d = 1'b0;
        case (mode_q)
            MODE_STEP: begin
                cpu_en_d = press;
                if (run_sw) mode_d = MODE_RUN;
            end
            MODE_RUN: begin
                cpu_en_d = tick;
                if (!run_sw) mode_d = MODE_STEP;
            end
            MODE_HALT: mode_d = MODE_HALT;
            default:   mode_d = MODE_STEP;
        endcase
        if (bus.halt_i) begin
            mode_d   = MODE_HALT;
            cpu_en_d = 1'b0;
        end
    end

    assign bus.cpu_en_o   = cpu_en_q;
    assign bus.mode_o     = mode_q;
    assign bus.step_cnt_o = step_cnt_q;
endmodule
